vga_frame_ctrl: RTL

//  Frame scheduler and game-state controller in front of vga_display. It accepts

---
 rtl/vga_pkg.sv | 21 ++
 rtl/frame_edge.sv | 25 ++
 rtl/vga_frame_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared display constants and the game-state encoding used by the frame controller.
// Pure declarations: no latency, no flow control.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int BALL_W   = 72;
  localparam int BALL_H   = 78;
  localparam int COL_BASE = 120;
  localparam int SCR_W    = 640;
  localparam int SCR_H    = 480;
  // Ball row/column limits that keep the sprite fully on screen.
  localparam int ROW_BASE = SCR_H - BALL_H;
  localparam int X_LIMIT  = SCR_W - COL_BASE - BALL_W;

endpackage

// File: rtl/frame_edge.sv
// Registers vsync and flags its falling edge as the frame boundary (fb, combinational).
// frame_tick follows fb by one cycle; no backpressure.
module frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic fb,
  output logic frame_tick
);

  logic vs_d;

  assign fb = vs_d & ~vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_d       <= vs;
      frame_tick <= fb;
    end
  end

endmodule

// File: rtl/vga_frame_ctrl.sv
// Buffers one physics update and commits it to the display only at a frame boundary; runs the game FSM.
// Commit/scroll land on the fb edge; upd_ready = PLAY & (buffer empty | fb), so a new beat may replace one that commits.
module vga_frame_ctrl
  import vga_pkg::*;
#(
  parameter int SCROLL_STEP = 4,
  parameter int OFF_MAX     = ROW_BASE,
  parameter int DIE_FRAMES  = 60,
  parameter int X_MAX       = X_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        start,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [9:0]  upd_x,
  input  logic [15:0] upd_y,
  input  logic [8:0]  upd_off_tgt,
  input  logic        upd_fail,
  output logic        frame_tick,
  output logic [9:0]  x_ball,
  output logic [15:0] y_ball,
  output logic [8:0]  y_pixel_offset,
  output logic        fail,
  output logic        playing
);

  localparam int DW = $clog2(DIE_FRAMES);
  localparam logic signed [9:0] STEP_S = 10'(SCROLL_STEP);

  state_t          state, state_nx;
  logic            fb;
  logic            pending;
  logic [9:0]      buf_x;
  logic [15:0]     buf_y;
  logic [8:0]      buf_off;
  logic            buf_fail;
  logic [8:0]      tgt, tgt_eff, off_nx;
  logic signed [9:0] d;
  logic [DW-1:0]   die_cnt;
  logic            accept, commit, die_last, go_play;

  frame_edge u_frame_edge (
    .clk        (clk),
    .rst        (rst),
    .vs         (vs),
    .fb         (fb),
    .frame_tick (frame_tick)
  );

  assign playing   = (state == ST_PLAY);
  assign upd_ready = playing & (~pending | fb);
  assign accept    = upd_valid & upd_ready;
  assign commit    = playing & fb & pending;
  assign die_last  = (die_cnt == DW'(DIE_FRAMES - 1));
  assign go_play   = (state == ST_IDLE) & start;
  // A beat committing on this fb steers the scroll immediately.
  assign tgt_eff   = pending ? buf_off : tgt;

  always_comb begin
    d      = $signed({1'b0, tgt_eff}) - $signed({1'b0, y_pixel_offset});
    off_nx = tgt_eff;
    if (d > STEP_S)
      off_nx = y_pixel_offset + 9'(SCROLL_STEP);
    else if (d < -STEP_S)
      off_nx = y_pixel_offset - 9'(SCROLL_STEP);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start) state_nx = ST_PLAY;
      ST_PLAY:  if (commit && buf_fail) state_nx = ST_DYING;
      ST_DYING: if (fb && die_last) state_nx = ST_OVER;
      ST_OVER:  if (start) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending        <= 1'b0;
      buf_x          <= '0;
      buf_y          <= '0;
      buf_off        <= '0;
      buf_fail       <= 1'b0;
      tgt            <= '0;
      x_ball         <= '0;
      y_ball         <= '0;
      y_pixel_offset <= '0;
      fail           <= 1'b0;
      die_cnt        <= '0;
    end else begin
      if (go_play)     pending <= 1'b0;
      else if (accept) pending <= 1'b1;
      else if (commit) pending <= 1'b0;

      if (accept) begin
        buf_x    <= (upd_x > 10'(X_MAX)) ? 10'(X_MAX) : upd_x;
        buf_y    <= upd_y;
        buf_off  <= (upd_off_tgt > 9'(OFF_MAX)) ? 9'(OFF_MAX) : upd_off_tgt;
        buf_fail <= upd_fail;
      end

      if (go_play) begin
        x_ball         <= '0;
        y_ball         <= '0;
        y_pixel_offset <= '0;
        tgt            <= '0;
      end else if (playing && fb) begin
        y_pixel_offset <= off_nx;
        if (pending) begin
          x_ball <= buf_x;
          y_ball <= buf_y;
          tgt    <= buf_off;
        end
      end

      if (playing)                       die_cnt <= '0;
      else if (state == ST_DYING && fb)  die_cnt <= die_cnt + 1'b1;

      if (state == ST_DYING && fb && die_last) fail <= 1'b1;
      else if (state == ST_OVER && start)      fail <= 1'b0;
    end
  end

endmodule
